// File: rtl/sol32_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sol32_fetch_unit
//  Purpose  : Instruction fetch unit for the SOL32 core. It issues sequential
//             word reads to instruction memory and buffers the returned words
//             in a small (address, data) FIFO. It presents the word that
//             matches the core's InstructionPointer. When the pointer leaves
//             the sequential stream, the unit redirects: it flushes the FIFO
//             and drops every read that is still in flight.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH         prefetch FIFO entries (power of two, 2..8)
//    RESET_VECTOR  address of the first fetch after reset
//  Ports
//    Clock               in   rising-edge clock
//    Reset               in   asynchronous, active-low reset
//    InstructionPointer  in   [31:0] address the core wants this cycle
//    InstructionAccept   in   core consumes Instruction at this edge
//    Instruction         out  [31:0] word for InstructionPointer (0 if none)
//    InstructionValid    out  Instruction valid and tagged InstructionPointer
//    FetchRequest        out  memory read request valid
//    FetchAddress        out  [31:0] word address of the request
//    FetchReady          in   memory accepts the request this cycle
//    FetchResponseValid  in   read data returned this cycle (in order)
//    FetchData           in   [31:0] returned instruction word
//  Configuration
//    FETCH_PREFETCH_EN   defined  : keep up to DEPTH words buffered/in flight
//                        undefined: one instruction at a time
// ============================================================================
module sol32_fetch_unit #(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] InstructionPointer,
    input  logic        InstructionAccept,
    output logic [31:0] Instruction,
    output logic        InstructionValid,
    output logic        FetchRequest,
    output logic [31:0] FetchAddress,
    input  logic        FetchReady,
    input  logic        FetchResponseValid,
    input  logic [31:0] FetchData
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy/credit counters hold at least 2*DEPTH.
    localparam int unsigned c_CNT_W = $clog2(2 * DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    // FIFO storage
    logic [31:0]        r_fifo_addr [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Request / delivery tracking
    logic [31:0]        r_next_addr;
    logic [31:0]        r_expected_addr;
    logic [31:0]        r_oldest_addr;   // address of oldest live in-flight read
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;

    logic               w_redirect;
    logic               w_hit;
    logic               w_pop;
    logic               w_resp_ok;
    logic               w_push;
    logic               w_xfer;
    logic               w_credit;
    logic [c_CNT_W-1:0] w_count_after_pop;
    logic [31:0]        w_head_addr;
    logic [31:0]        w_head_data;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // Any pointer other than the next sequential address is a branch target.
    assign w_redirect = (InstructionPointer != r_expected_addr);

    assign w_hit = (r_count != '0) && !w_redirect
                   && (w_head_addr == InstructionPointer);
    assign InstructionValid = w_hit;
    assign Instruction      = w_hit ? w_head_data : 32'h0000_0000;
    assign w_pop            = w_hit && InstructionAccept;

    // A response with nothing outstanding violates the memory protocol; ignore it.
    assign w_resp_ok = FetchResponseValid && (r_outstanding != '0);
    // Push only live words. The room check guards the FIFO if the memory
    // misbehaves; the credit rule keeps it from ever triggering in normal use.
    assign w_push    = w_resp_ok && (r_discard == '0) && !w_redirect
                       && ((r_count != c_DEPTH) || w_pop);

    // Credit counts the slot freed by a same-cycle pop. This lets a DEPTH-2
    // FIFO sustain one word per cycle against single-cycle memory.
    assign w_count_after_pop = r_count - c_CNT_W'(w_pop);

`ifdef FETCH_PREFETCH_EN
    logic [c_CNT_W-1:0] w_live;
    // Discarded reads never occupy a FIFO slot, so they earn their credit back.
    assign w_live   = w_count_after_pop + (r_outstanding - r_discard);
    assign w_credit = (w_live < c_DEPTH);
`else
    assign w_credit = (w_count_after_pop == '0) && (r_outstanding == '0);
`endif

    // Reset gates the request combinationally so nothing leaks out while held.
    assign FetchRequest = Reset && !w_redirect && w_credit;
    assign FetchAddress = r_next_addr;
    assign w_xfer       = FetchRequest && FetchReady;

    // Payload storage needs no reset: the count qualifies every entry.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_oldest_addr;
            r_fifo_data[r_wr_ptr] <= FetchData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_next_addr     <= RESET_VECTOR;
            r_expected_addr <= RESET_VECTOR;
            r_oldest_addr   <= RESET_VECTOR;
            r_outstanding   <= '0;
            r_discard       <= '0;
        end else begin
            r_outstanding <= r_outstanding + c_CNT_W'(w_xfer) - c_CNT_W'(w_resp_ok);
            if (w_redirect) begin
                // Everything still in flight belongs to the old stream. No
                // transfer happens this cycle, and this cycle's response is dropped.
                r_rd_ptr        <= '0;
                r_wr_ptr        <= '0;
                r_count         <= '0;
                r_discard       <= r_outstanding - c_CNT_W'(w_resp_ok);
                r_next_addr     <= InstructionPointer;
                r_expected_addr <= InstructionPointer;
                r_oldest_addr   <= InstructionPointer;
            end else begin
                if (w_xfer) begin
                    r_next_addr <= r_next_addr + 32'd4;
                end
                if (w_resp_ok && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr      <= r_wr_ptr + 1'b1;
                    r_oldest_addr <= r_oldest_addr + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr        <= r_rd_ptr + 1'b1;
                    r_expected_addr <= r_expected_addr + 32'd4;
                end
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sol32_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sol32_fetch_unit
//  Purpose  : Directed self-checking bench for sol32_fetch_unit (DEPTH=2,
//             RESET_VECTOR=0). The bench contains an in-order memory model
//             with programmable latency. Each returned word is derived from
//             its address, so a word delivered with the wrong tag is visible.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sol32_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam bit c_PF = 1'b1;
`else
    localparam bit c_PF = 1'b0;
`endif

    logic        Clock;
    logic        Reset;
    logic [31:0] InstructionPointer;
    logic        InstructionAccept;
    logic [31:0] Instruction;
    logic        InstructionValid;
    logic        FetchRequest;
    logic [31:0] FetchAddress;
    logic        FetchReady;
    logic        FetchResponseValid;
    logic [31:0] FetchData;

    int total;
    int bad;
    int lat;
    int max_inflight;
    logic [31:0] mq_addr[$];
    int          mq_age[$];

    sol32_fetch_unit #(
        .DEPTH        (2),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .InstructionPointer (InstructionPointer),
        .InstructionAccept  (InstructionAccept),
        .Instruction        (Instruction),
        .InstructionValid   (InstructionValid),
        .FetchRequest       (FetchRequest),
        .FetchAddress       (FetchAddress),
        .FetchReady         (FetchReady),
        .FetchResponseValid (FetchResponseValid),
        .FetchData          (FetchData)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // In-order memory: a read transferred at an edge responds lat-1 cycles
    // after that edge, one response per cycle.
    initial begin
        logic xfer;
        logic taken;
        logic [31:0] xaddr;
        FetchResponseValid = 1'b0;
        FetchData = 32'h0;
        forever begin
            @(negedge Clock);
            xfer  = FetchRequest && FetchReady;
            xaddr = FetchAddress;
            taken = FetchResponseValid;
            @(posedge Clock);
            #1;
            if (!Reset) begin
                mq_addr.delete();
                mq_age.delete();
            end else begin
                if (taken && mq_addr.size() > 0) begin
                    void'(mq_addr.pop_front());
                    void'(mq_age.pop_front());
                end
                foreach (mq_age[i]) mq_age[i] = mq_age[i] + 1;
                if (xfer) begin
                    mq_addr.push_back(xaddr);
                    mq_age.push_back(0);
                end
            end
            if (mq_addr.size() > max_inflight) max_inflight = mq_addr.size();
            if (mq_addr.size() > 0 && mq_age[0] >= lat - 1) begin
                FetchResponseValid = 1'b1;
                FetchData = word_of(mq_addr[0]);
            end else begin
                FetchResponseValid = 1'b0;
                FetchData = 32'h0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset(input logic [31:0] ip0, input logic acc, input logic rdy, input int l);
        next_cycle();
        Reset = 1'b0;
        InstructionPointer = ip0;
        InstructionAccept = acc;
        FetchReady = rdy;
        lat = l;
        repeat (2) @(posedge Clock);
        #2;
        Reset = 1'b1;
        max_inflight = 0;
    endtask

    task automatic test_reset();
        @(negedge Clock);
        total++;
        if (FetchRequest !== 1'b0 || InstructionValid !== 1'b0 || Instruction !== 32'h0
            || FetchAddress !== 32'h0) begin
            bad++;
            $display("FAIL reset_state req=%b valid=%b instr=%h addr=%h exp 0/0/0/0",
                     FetchRequest, InstructionValid, Instruction, FetchAddress);
        end
        next_cycle();
        Reset = 1'b1;
        InstructionPointer = 32'h0;
        InstructionAccept = 1'b0;
        max_inflight = 0;
        @(negedge Clock);
        total++;
        if (FetchRequest !== 1'b1 || FetchAddress !== 32'h0) begin
            bad++;
            $display("FAIL first_request req=%b addr=%h exp 1/00000000", FetchRequest, FetchAddress);
        end
        repeat (3) next_cycle();
        @(negedge Clock);
        total++;
        if (InstructionValid !== 1'b1 || Instruction !== word_of(32'h0)) begin
            bad++;
            $display("FAIL pre_async valid=%b instr=%h exp 1/%h", InstructionValid, Instruction,
                     word_of(32'h0));
        end
        #2;
        Reset = 1'b0;
        #1;
        total++;
        if (FetchRequest !== 1'b0 || InstructionValid !== 1'b0 || Instruction !== 32'h0
            || FetchAddress !== 32'h0) begin
            bad++;
            $display("FAIL async_reset req=%b valid=%b instr=%h addr=%h exp 0/0/0/0",
                     FetchRequest, InstructionValid, Instruction, FetchAddress);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] ip;
        logic [31:0] exp_req;
        bit v;
        bit ev;
        ip = 32'h0;
        exp_req = 32'h0;
        v = 1'b0;
        do_reset(32'h0, 1'b1, 1'b1, 1);
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                next_cycle();
                if (v) ip = ip + 32'd4;
                InstructionPointer = ip;
            end
            @(negedge Clock);
            if (FetchRequest && FetchReady) begin
                total++;
                if (FetchAddress !== exp_req) begin
                    bad++;
                    $display("FAIL seq_addr c=%0d got=%h exp=%h", c, FetchAddress, exp_req);
                end
                exp_req = exp_req + 32'd4;
            end
            v  = InstructionValid;
            ev = (c >= 2) && (c_PF || (c % 2 == 0));
            total++;
            if (v !== ev) begin
                bad++;
                $display("FAIL seq_valid c=%0d got=%b exp=%b", c, v, ev);
            end
            if (v) begin
                total++;
                if (Instruction !== word_of(ip)) begin
                    bad++;
                    $display("FAIL seq_data c=%0d got=%h exp=%h", c, Instruction, word_of(ip));
                end
            end
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset(32'h0, 1'b0, 1'b0, 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            @(negedge Clock);
            total++;
            if (FetchRequest !== 1'b1 || FetchAddress !== 32'h0) begin
                bad++;
                $display("FAIL stall_hold c=%0d req=%b addr=%h exp 1/00000000", c, FetchRequest,
                         FetchAddress);
            end
        end
        next_cycle();
        FetchReady = 1'b1;
        n = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            @(negedge Clock);
            if (FetchRequest && FetchReady) begin
                total++;
                if (FetchAddress !== 32'(4 * n)) begin
                    bad++;
                    $display("FAIL stall_addr n=%0d got=%h exp=%h", n, FetchAddress, 32'(4 * n));
                end
                n++;
            end
        end
        total++;
        if (n != (c_PF ? 2 : 1)) begin
            bad++;
            $display("FAIL stall_count got=%0d exp=%0d", n, (c_PF ? 2 : 1));
        end
        total++;
        if (InstructionValid !== 1'b1 || Instruction !== word_of(32'h0)) begin
            bad++;
            $display("FAIL stall_head valid=%b instr=%h exp 1/%h", InstructionValid, Instruction,
                     word_of(32'h0));
        end
    endtask

    task automatic test_redirect();
        int k;
        bit got_req;
        bit got_valid;
        do_reset(32'h10, 1'b0, 1'b1, 3);
        @(negedge Clock);
        total++;
        if (FetchRequest !== 1'b0 || InstructionValid !== 1'b0) begin
            bad++;
            $display("FAIL redir_first req=%b valid=%b exp 0/0", FetchRequest, InstructionValid);
        end
        k = 0;
        for (int c = 1; c < 3; c++) begin
            next_cycle();
            @(negedge Clock);
            if (FetchRequest && FetchReady) begin
                total++;
                if (FetchAddress !== 32'h10 + 32'(4 * k)) begin
                    bad++;
                    $display("FAIL redir_pre_addr c=%0d got=%h exp=%h", c, FetchAddress,
                             32'h10 + 32'(4 * k));
                end
                k++;
            end
        end
        next_cycle();
        InstructionPointer = 32'h100;
        @(negedge Clock);
        total++;
        if (FetchRequest !== 1'b0 || InstructionValid !== 1'b0 || mq_addr.size() != (c_PF ? 2 : 1)) begin
            bad++;
            $display("FAIL redir_cycle req=%b valid=%b inflight=%0d exp 0/0/%0d", FetchRequest,
                     InstructionValid, mq_addr.size(), (c_PF ? 2 : 1));
        end
        got_req = 1'b0;
        got_valid = 1'b0;
        for (int c = 4; c < 20; c++) begin
            next_cycle();
            @(negedge Clock);
            if (!got_req && FetchRequest && FetchReady) begin
                got_req = 1'b1;
                total++;
                if (FetchAddress !== 32'h100 || c != (c_PF ? 4 : 5)) begin
                    bad++;
                    $display("FAIL redir_req got=%h@%0d exp=00000100@%0d", FetchAddress, c,
                             (c_PF ? 4 : 5));
                end
            end
            if (!got_valid && InstructionValid) begin
                got_valid = 1'b1;
                total++;
                if (Instruction !== word_of(32'h100) || c != (c_PF ? 8 : 9)) begin
                    bad++;
                    $display("FAIL redir_hit got=%h@%0d exp=%h@%0d", Instruction, c,
                             word_of(32'h100), (c_PF ? 8 : 9));
                end
            end
        end
        if (!got_req || !got_valid) begin
            total++;
            bad++;
            $display("FAIL redir_timeout req_seen=%b valid_seen=%b exp 1/1", got_req, got_valid);
        end
    endtask

    task automatic test_full();
        logic [31:0] ip;
        bit v;
        bit ev;
        ip = 32'h0;
        do_reset(32'h0, 1'b0, 1'b1, 1);
        repeat (5) next_cycle();
        @(negedge Clock);
        total++;
        if (FetchRequest !== 1'b0 || InstructionValid !== 1'b1 || Instruction !== word_of(32'h0)) begin
            bad++;
            $display("FAIL full_idle req=%b valid=%b instr=%h exp 0/1/%h", FetchRequest,
                     InstructionValid, Instruction, word_of(32'h0));
        end
        next_cycle();
        InstructionAccept = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge Clock);
            v  = InstructionValid;
            ev = c_PF || (j % 2 == 0);
            total++;
            if (v !== ev) begin
                bad++;
                $display("FAIL full_valid j=%0d got=%b exp=%b", j, v, ev);
            end
            if (v) begin
                total++;
                if (Instruction !== word_of(ip)) begin
                    bad++;
                    $display("FAIL full_data j=%0d got=%h exp=%h", j, Instruction, word_of(ip));
                end
            end
            next_cycle();
            if (v) ip = ip + 32'd4;
            InstructionPointer = ip;
        end
        InstructionAccept = 1'b0;
        repeat (3) next_cycle();
        @(negedge Clock);
        total++;
        if (FetchRequest !== 1'b0 || InstructionValid !== 1'b1 || Instruction !== word_of(ip)) begin
            bad++;
            $display("FAIL full_refill req=%b valid=%b instr=%h exp 0/1/%h", FetchRequest,
                     InstructionValid, Instruction, word_of(ip));
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ip;
        logic [31:0] exp_req;
        bit v;
        bit ev;
        bit saw_zero;
        ip = 32'hFFFF_FFF8;
        exp_req = 32'hFFFF_FFF8;
        v = 1'b0;
        saw_zero = 1'b0;
        do_reset(32'hFFFF_FFF8, 1'b1, 1'b1, 1);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                next_cycle();
                if (v) ip = ip + 32'd4;
                InstructionPointer = ip;
            end
            @(negedge Clock);
            if (FetchRequest && FetchReady) begin
                total++;
                if (FetchAddress !== exp_req) begin
                    bad++;
                    $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, FetchAddress, exp_req);
                end
                if (exp_req == 32'h0) saw_zero = 1'b1;
                exp_req = exp_req + 32'd4;
            end
            v  = InstructionValid;
            ev = (c >= 3) && (c_PF || (c % 2 == 1));
            total++;
            if (v !== ev) begin
                bad++;
                $display("FAIL wrap_valid c=%0d got=%b exp=%b", c, v, ev);
            end
            if (v) begin
                total++;
                if (Instruction !== word_of(ip)) begin
                    bad++;
                    $display("FAIL wrap_data c=%0d got=%h exp=%h", c, Instruction, word_of(ip));
                end
            end
        end
        total++;
        if (saw_zero !== 1'b1) begin
            bad++;
            $display("FAIL wrap_zero got=%b exp=1", saw_zero);
        end
    endtask

    task automatic test_slow_memory();
        logic [31:0] ip;
        bit v;
        bit ev;
        ip = 32'h0;
        v = 1'b0;
        do_reset(32'h0, 1'b1, 1'b1, 3);
        for (int c = 0; c < 17; c++) begin
            if (c > 0) begin
                next_cycle();
                if (v) ip = ip + 32'd4;
                InstructionPointer = ip;
            end
            @(negedge Clock);
            v = InstructionValid;
            if (c_PF) ev = (c >= 4) && ((c % 4 == 0) || (c % 4 == 1));
            else      ev = (c >= 4) && (c % 4 == 0);
            total++;
            if (v !== ev) begin
                bad++;
                $display("FAIL slow_valid c=%0d got=%b exp=%b", c, v, ev);
            end
            if (v) begin
                total++;
                if (Instruction !== word_of(ip)) begin
                    bad++;
                    $display("FAIL slow_data c=%0d got=%h exp=%h", c, Instruction, word_of(ip));
                end
            end
        end
        total++;
        if (max_inflight != (c_PF ? 2 : 1)) begin
            bad++;
            $display("FAIL slow_inflight got=%0d exp=%0d", max_inflight, (c_PF ? 2 : 1));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        lat = 1;
        max_inflight = 0;
        Reset = 1'b0;
        InstructionPointer = 32'h40;
        InstructionAccept = 1'b1;
        FetchReady = 1'b1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_full();
        test_wrap();
        test_slow_memory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
